// File: rtl/led_mode_sequencer.sv
// Four-pattern running-light controller for an 8-LED display.
// Patterns advance on divider ticks; the mode changes on a button edge or after PASSES passes.
module led_mode_sequencer #(
  parameter int unsigned PASSES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       auto_en,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       pass_done
);

  typedef enum logic [1:0] {
    ModeL2r  = 2'd0,
    ModeR2l  = 2'd1,
    ModePing = 2'd2,
    ModeFill = 2'd3
  } mode_e;

  localparam logic [3:0] PassesW = 4'(PASSES);

  mode_e      r_mode, w_mode_d;
  logic [7:0] r_led, w_led_d;
  logic       r_dir, w_dir_d;  // ping-pong: 0 = shifting right (down), 1 = shifting left (up)
  logic [3:0] r_cnt, w_cnt_d;
  logic       r_btn;
  logic       r_pass_done, w_pass_done_d;

  logic       w_btn_edge;
  logic [7:0] w_step_led;
  logic       w_step_dir;
  logic       w_wrap;
  logic [3:0] w_cnt_inc;
  logic       w_auto_adv;
  mode_e      w_next_mode;
  logic [7:0] w_start_led;

  assign w_btn_edge  = mode_btn & ~r_btn;
  assign w_next_mode = mode_e'(r_mode + 2'd1);
  assign w_cnt_inc   = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  assign w_auto_adv  = auto_en && (w_cnt_inc >= PassesW);

  always_comb begin
    w_start_led = 8'h80;
    unique case (w_next_mode)
      ModeL2r:  w_start_led = 8'h80;
      ModeR2l:  w_start_led = 8'h01;
      ModePing: w_start_led = 8'h80;
      ModeFill: w_start_led = 8'h00;
      default:  w_start_led = 8'h80;
    endcase
  end

  // One pattern step from the current LED value; w_wrap marks the pass-completing step.
  always_comb begin
    w_step_led = r_led;
    w_step_dir = r_dir;
    w_wrap     = 1'b0;
    unique case (r_mode)
      ModeL2r: begin
        w_wrap     = (r_led == 8'h01);
        w_step_led = w_wrap ? 8'h80 : (r_led >> 1);
      end
      ModeR2l: begin
        w_wrap     = (r_led == 8'h80);
        w_step_led = w_wrap ? 8'h01 : (r_led << 1);
      end
      ModePing: begin
        if (!r_dir) begin
          if (r_led == 8'h01) begin
            w_step_led = 8'h02;
            w_step_dir = 1'b1;
          end else begin
            w_step_led = r_led >> 1;
          end
        end else begin
          w_wrap = (r_led == 8'h40);
          if (r_led == 8'h80) begin
            w_step_led = 8'h40;
            w_step_dir = 1'b0;
          end else begin
            w_step_led = r_led << 1;
          end
        end
      end
      ModeFill: begin
        w_wrap     = (r_led == 8'hFF);
        w_step_led = w_wrap ? 8'h00 : {1'b1, r_led[7:1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_mode_d      = r_mode;
    w_led_d       = r_led;
    w_dir_d       = r_dir;
    w_cnt_d       = r_cnt;
    w_pass_done_d = 1'b0;
    if (w_btn_edge) begin
      // A button edge discards any coincident tick.
      w_mode_d = w_next_mode;
      w_led_d  = w_start_led;
      w_dir_d  = 1'b0;
      w_cnt_d  = 4'd0;
    end else if (tick) begin
      if (w_wrap) begin
        w_pass_done_d = 1'b1;
        w_cnt_d       = w_cnt_inc;
      end
      if (w_wrap && w_auto_adv) begin
        w_mode_d = w_next_mode;
        w_led_d  = w_start_led;
        w_dir_d  = 1'b0;
        w_cnt_d  = 4'd0;
      end else begin
        w_led_d = w_step_led;
        w_dir_d = w_step_dir;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode      <= ModeL2r;
      r_led       <= 8'h80;
      r_dir       <= 1'b0;
      r_cnt       <= 4'd0;
      r_btn       <= 1'b1;
      r_pass_done <= 1'b0;
    end else begin
      r_mode      <= w_mode_d;
      r_led       <= w_led_d;
      r_dir       <= w_dir_d;
      r_cnt       <= w_cnt_d;
      r_btn       <= mode_btn;
      r_pass_done <= w_pass_done_d;
    end
  end

  assign led       = r_led;
  assign mode      = r_mode;
  assign pass_done = r_pass_done;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Scoreboard bench for led_mode_sequencer: a position-based pattern model predicts every cycle.
module tb_led_mode_sequencer;
  localparam int unsigned P = 2;

  logic       clk = 1'b0;
  logic       reset, tick, mode_btn, auto_en;
  logic [7:0] led;
  logic [1:0] mode;
  logic       pass_done;

  led_mode_sequencer #(.PASSES(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .mode_btn (mode_btn),
    .auto_en  (auto_en),
    .led      (led),
    .mode     (mode),
    .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] led;
    logic       pd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int m_mode, m_pos, m_cnt;
  bit m_btn, m_pd;

  function automatic int plen(input int m);
    case (m)
      0, 1:    return 8;
      2:       return 14;
      default: return 9;
    endcase
  endfunction

  function automatic logic [7:0] mled(input int m, input int p);
    logic [7:0] hi, lo, ones;
    hi = 8'h80; lo = 8'h01; ones = 8'hFF;
    case (m)
      0:       return hi >> p;
      1:       return lo << p;
      2:       return (p <= 7) ? (hi >> p) : (hi >> (14 - p));
      default: return (p == 0) ? 8'h00 : ~(ones >> p);
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_cnt = 0; m_btn = 1'b1; m_pd = 1'b0;
  endtask

  task automatic model_enter(input int n);
    m_mode = n % 4; m_pos = 0; m_cnt = 0;
  endtask

  // Drive one cycle, predict its outcome and queue it for the monitor.
  task automatic step(input bit t, input bit b, input bit a);
    bit edge_seen;
    exp_t e;
    tick = t; mode_btn = b; auto_en = a;
    edge_seen = b && !m_btn;
    m_btn = b;
    m_pd = 1'b0;
    if (edge_seen) begin
      model_enter(m_mode + 1);
    end else if (t) begin
      if (m_pos == plen(m_mode) - 1) begin
        m_pd = 1'b1;
        if (m_cnt < 15) m_cnt++;
        if (a && m_cnt >= P) model_enter(m_mode + 1);
        else m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    e.mode = 2'(m_mode);
    e.led  = mled(m_mode, m_pos);
    e.pd   = m_pd;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({mode, led, pass_done} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got mode=%0d led=%h pd=%b, expected mode=%0d led=%h pd=%b",
                 $time, mode, led, pass_done, e.mode, e.led, e.pd);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; tick = 1'b0; mode_btn = 1'b0; auto_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led !== 8'h80 || mode !== 2'd0 || pass_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got led=%h mode=%0d pd=%b, expected led=80 mode=0 pd=0",
               led, mode, pass_done);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_l2r();
    int n_pd, at_pd;
    n_pd = 0; at_pd = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (pass_done) begin n_pd++; at_pd = i; end
    end
    checks++;
    if (n_pd !== 1 || at_pd !== 8 || mode !== 2'd0) begin
      errors++;
      $display("FAIL l2r_pass: got pulses=%0d at=%0d mode=%0d, expected pulses=1 at=8 mode=0",
               n_pd, at_pd, mode);
    end
  endtask

  task automatic test_button();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (mode !== 2'd1 || led !== 8'h01) begin
      errors++;
      $display("FAIL button_adv: got mode=%0d led=%h, expected mode=1 led=01", mode, led);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (led !== 8'h02) begin
      errors++;
      $display("FAIL r2l_first_tick: got led=%h, expected led=02", led);
    end
  endtask

  task automatic test_pingpong_auto();
    int n_pd;
    bit ok14;
    n_pd = 0; ok14 = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 28; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (pass_done) begin
        n_pd++;
        if (i == 14) ok14 = 1'b1;
      end
    end
    checks++;
    if (n_pd !== 2 || !ok14 || mode !== 2'd3 || led !== 8'h00) begin
      errors++;
      $display("FAIL pingpong_auto: got pulses=%0d p14=%b mode=%0d led=%h, expected 2 1 3 00",
               n_pd, ok14, mode, led);
    end
  endtask

  task automatic test_fill_auto();
    int n_pd;
    n_pd = 0;
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (pass_done) n_pd++;
    end
    checks++;
    if (n_pd !== 2 || mode !== 2'd0 || led !== 8'h80) begin
      errors++;
      $display("FAIL fill_auto: got pulses=%0d mode=%0d led=%h, expected 2 0 80", n_pd, mode, led);
    end
  endtask

  task automatic test_btn_tick();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (mode !== 2'd1 || led !== 8'h01 || pass_done !== 1'b0) begin
      errors++;
      $display("FAIL btn_with_tick: got mode=%0d led=%h pd=%b, expected mode=1 led=01 pd=0",
               mode, led, pass_done);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_auto_toggle();
    // 16 passes with auto off saturate the counter; re-enabling advances at the next wrap.
    repeat (131) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL auto_off_hold: got mode=%0d, expected mode=1", mode);
    end
    repeat (5) step(1'b1, 1'b0, 1'b1);
    checks++;
    if (mode !== 2'd2 || led !== 8'h80) begin
      errors++;
      $display("FAIL auto_reenable: got mode=%0d led=%h, expected mode=2 led=80", mode, led);
    end
  endtask

  task automatic test_reset_mid();
    repeat (9) step(1'b1, 1'b0, 1'b0);
    mode_btn = 1'b1;
    tick     = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (led !== 8'h80 || mode !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got led=%h mode=%0d, expected led=80 mode=0", led, mode);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (led !== 8'h40 || mode !== 2'd0) begin
      errors++;
      $display("FAIL held_btn_release: got led=%h mode=%0d, expected led=40 mode=0", led, mode);
    end
  endtask

  initial begin
    test_reset();
    test_l2r();
    test_button();
    test_pingpong_auto();
    test_fill_auto();
    test_btn_tick();
    test_auto_toggle();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
